// File: rtl/press_pkg.sv
// Shared encodings for the press classifier and future event consumers.
// The tick-window helper is used to size the shared tick counter.
package press_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRESS1    = 3'd1;
  localparam logic [2:0] S_LONG_HELD = 3'd2;
  localparam logic [2:0] S_GAP       = 3'd3;
  localparam logic [2:0] S_PRESS2    = 3'd4;

  localparam logic [1:0] EVT_SHORT  = 2'd0;
  localparam logic [1:0] EVT_LONG   = 2'd1;
  localparam logic [1:0] EVT_DOUBLE = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/press_classifier_tick_counter.sv
// Counts m_tick strobes while enabled; o_match flags the tick that lands
// on the terminal count supplied at runtime.
module tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic         i_m_tick,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_count,
  output logic         o_match
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_count <= '0;
    end else if (i_enable && i_m_tick) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
  assign o_match = i_enable && i_m_tick && (r_count == i_limit);

endmodule

// File: rtl/press_classifier.sv
// Classifies each debounced press as short, long or double and emits a
// one-cycle pulse per event, plus a wrapping count of all events.
module press_classifier
  import press_pkg::*;
#(
  parameter int LONG_TICKS   = 50,
  parameter int DCLICK_TICKS = 25,
  parameter int EVT_W        = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             m_tick,
  input  logic             level,
  output logic             short_press,
  output logic             long_press,
  output logic             double_press,
  output logic [EVT_W-1:0] evt_count
);

  localparam int TW = $clog2(max_int(LONG_TICKS, DCLICK_TICKS) + 1);
  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_TICKS - 1);
  localparam logic [TW-1:0] DCLICK_LAST = TW'(DCLICK_TICKS - 1);

  logic [2:0]       r_state;
  logic             r_short;
  logic             r_long;
  logic             r_double;
  logic [EVT_W-1:0] r_evt_count;

  logic          w_in_press1;
  logic          w_in_gap;
  logic          w_match;
  logic          w_leave;
  logic          w_fire_short;
  logic          w_fire_long;
  logic          w_fire_double;
  logic          w_fire_any;
  logic [TW-1:0] w_limit;
  logic [TW-1:0] w_tcnt_unused;

  assign w_in_press1 = (r_state == S_PRESS1);
  assign w_in_gap    = (r_state == S_GAP);
  assign w_limit     = w_in_gap ? DCLICK_LAST : LONG_LAST;

  // A level change always beats a timeout landing on the same cycle.
  assign w_fire_long   = w_in_press1 && level && w_match;
  assign w_fire_double = w_in_gap && level;
  assign w_fire_short  = w_in_gap && !level && w_match;
  assign w_fire_any    = w_fire_short || w_fire_long || w_fire_double;

  always_comb begin
    w_leave = 1'b0;
    case (r_state)
      S_IDLE:                 w_leave = level;
      S_PRESS1:               w_leave = !level || w_match;
      S_LONG_HELD, S_PRESS2:  w_leave = !level;
      S_GAP:                  w_leave = level || w_match;
      default:                w_leave = 1'b1;
    endcase
  end

  tick_counter #(.W(TW)) u_tick_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_leave),
    .i_enable (w_in_press1 || w_in_gap),
    .i_m_tick (m_tick),
    .i_limit  (w_limit),
    .o_count  (w_tcnt_unused),
    .o_match  (w_match)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_short     <= 1'b0;
      r_long      <= 1'b0;
      r_double    <= 1'b0;
      r_evt_count <= '0;
    end else begin
      r_short  <= w_fire_short;
      r_long   <= w_fire_long;
      r_double <= w_fire_double;
      if (w_fire_any) begin
        r_evt_count <= r_evt_count + EVT_W'(1);
      end
      case (r_state)
        S_IDLE:      if (level) r_state <= S_PRESS1;
        S_PRESS1:    if (!level) r_state <= S_GAP;
                     else if (w_match) r_state <= S_LONG_HELD;
        S_LONG_HELD: if (!level) r_state <= S_IDLE;
        S_GAP:       if (level) r_state <= S_PRESS2;
                     else if (w_match) r_state <= S_IDLE;
        S_PRESS2:    if (!level) r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign short_press  = r_short;
  assign long_press   = r_long;
  assign double_press = r_double;
  assign evt_count    = r_evt_count;

endmodule
